// File: rtl/program_loader.sv
// Byte-stream program loader: packs bytes MSB-first into instruction words and
// writes them to consecutive instruction-memory addresses while stalling the core.
module program_loader #(
  parameter int INSTRUCTION_WIDTH = 40,
  parameter int PC_WIDTH          = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [PC_WIDTH-1:0]          base_addr,
  input  logic [PC_WIDTH:0]            length,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         wr_en,
  output logic [PC_WIDTH-1:0]          wr_addr,
  output logic [INSTRUCTION_WIDTH-1:0] wr_data,
  output logic                         busy,
  output logic                         done
);

  localparam int NBYTES = (INSTRUCTION_WIDTH + 7) / 8;
  localparam int SW     = NBYTES * 8;
  localparam int BCW    = $clog2(NBYTES + 1);

  // Handshake: a byte transfers on a rising edge where in_valid and in_ready
  // are both high; in_ready depends only on loader state, never on in_valid.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [BCW-1:0]  byte_cnt;
  logic [PC_WIDTH:0] word_cnt;
  logic [SW-9:0]   shreg;
  logic [SW-1:0]   sh_next;
  logic            hs;

  // Only the first NBYTES-1 bytes are stored; the last byte completes the word directly.
  assign sh_next = {shreg, in_data};
  assign hs      = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      byte_cnt <= '0;
      word_cnt <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (length != '0) begin
              wr_addr  <= base_addr;
              word_cnt <= length;
              byte_cnt <= '0;
              in_ready <= 1'b1;
              state    <= RECV;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RECV: begin
          if (hs) begin
            shreg <= sh_next[SW-9:0];
            if (byte_cnt == BCW'(NBYTES - 1)) begin
              wr_data  <= sh_next[INSTRUCTION_WIDTH-1:0];
              wr_en    <= 1'b1;
              in_ready <= 1'b0;
              state    <= WRITE;
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
        end
        WRITE: begin
          wr_en    <= 1'b0;
          wr_addr  <= wr_addr + PC_WIDTH'(1);
          word_cnt <= word_cnt - (PC_WIDTH+1)'(1);
          byte_cnt <= '0;
          if (word_cnt == (PC_WIDTH+1)'(1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= RECV;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: expected {addr,data} writes are queued
// as words are driven and compared when wr_en is observed.
module tb_program_loader;

  localparam int IW = 40;
  localparam int PW = 5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [PW-1:0] base_addr;
  logic [PW:0]   length;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [PW-1:0] wr_addr;
  logic [IW-1:0] wr_data;
  logic          busy;
  logic          done;

  logic [PW+IW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int wr_cnt = 0;

  program_loader #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) hs_cnt++;
      if (done) done_cnt++;
      if (wr_en) begin
        wr_cnt++;
        check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          logic [PW+IW-1:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e[PW+IW-1:IW]));
          check("wr_data", 64'(wr_data), 64'(e[IW-1:0]));
        end
        check("ready_in_write", 64'(in_ready), 64'd0);
      end
    end
  end

  // driver tasks (all called at a falling edge)
  task automatic do_start(input logic [PW-1:0] b, input logic [PW:0] l);
    start = 1'b1; base_addr = b; length = l;
    @(negedge clk);
    start = 1'b0; base_addr = $urandom_range(0, 31); length = $urandom_range(0, 32);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    in_data = b; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("hs_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data = $urandom_range(0, 255);
  endtask

  task automatic send_word(input logic [IW-1:0] w, input int maxgap);
    for (int i = 0; i < 5; i++) send_byte(w[IW-1-8*i -: 8], $urandom_range(0, maxgap));
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 64'(done), 64'd1);
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
  endtask

  initial begin
    logic [IW-1:0] w;
    int hs0, done0, wr0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    in_data = '0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single word, back-to-back bytes, latency checks
    do_start(5'd0, 6'd1);
    exp_q.push_back({5'd0, 40'h123456789A});
    send_word(40'h123456789A, 0);
    check("t1_wr_en_n1", 64'(wr_en), 64'd1);
    @(negedge clk);
    check("t1_done_n2", 64'(done), 64'd1);
    check("t1_busy_n2", 64'(busy), 64'd1);
    @(negedge clk);
    check("t1_busy_n3", 64'(busy), 64'd0);
    check("t1_done_n3", 64'(done), 64'd0);
    check("t1_addr_next", 64'(wr_addr), 64'd1);

    // three words with random valid gaps
    hs0 = hs_cnt;
    do_start(5'd3, 6'd3);
    for (int k = 0; k < 3; k++) begin
      w = {$urandom, 8'($urandom)};
      exp_q.push_back({5'(3 + k), w});
      send_word(w, 3);
    end
    wait_done();
    check("t2_bytes", 64'(hs_cnt - hs0), 64'd15);
    check("t2_q_empty", 64'(exp_q.size()), 64'd0);

    // address wrap 30,31,0,1
    do_start(5'd30, 6'd4);
    for (int k = 0; k < 4; k++) begin
      w = {$urandom, 8'($urandom)};
      exp_q.push_back({5'(30 + k), w});
      send_word(w, 0);
    end
    wait_done();
    check("t3_addr_after", 64'(wr_addr), 64'd2);

    // zero-length load
    wr0 = wr_cnt; hs0 = hs_cnt; done0 = done_cnt;
    in_valid = 1'b1; in_data = 8'hA5;
    do_start(5'd7, 6'd0);
    check("t4_done", 64'(done), 64'd1);
    check("t4_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("t4_done_gone", 64'(done), 64'd0);
    check("t4_busy_low", 64'(busy), 64'd0);
    in_valid = 1'b0;
    check("t4_no_write", 64'(wr_cnt - wr0), 64'd0);
    check("t4_no_bytes", 64'(hs_cnt - hs0), 64'd0);
    check("t4_one_done", 64'(done_cnt - done0), 64'd1);

    // reset mid-word, then restart
    do_start(5'd7, 6'd1);
    send_byte(8'hDE, 0); send_byte(8'hAD, 1); send_byte(8'hBE, 0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ready", 64'(in_ready), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_addr", 64'(wr_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr0 = wr_cnt;
    do_start(5'd9, 6'd1);
    exp_q.push_back({5'd9, 40'hCAFEF00D42});
    send_word(40'hCAFEF00D42, 1);
    wait_done();
    check("t5_one_write", 64'(wr_cnt - wr0), 64'd1);
    check("t5_addr_after", 64'(wr_addr), 64'd10);

    // valid while idle, and a second start mid-load
    hs0 = hs_cnt; done0 = done_cnt; wr0 = wr_cnt;
    in_valid = 1'b1; in_data = 8'hEE;
    repeat (4) @(negedge clk);
    check("t6_idle_ready", 64'(in_ready), 64'd0);
    check("t6_idle_bytes", 64'(hs_cnt - hs0), 64'd0);
    in_valid = 1'b0;
    do_start(5'd12, 6'd2);
    w = 40'h0102030405;
    exp_q.push_back({5'd12, w});
    send_byte(w[39:32], 0); send_byte(w[31:24], 0);
    do_start(5'd20, 6'd1);
    send_byte(w[23:16], 0); send_byte(w[15:8], 0); send_byte(w[7:0], 0);
    w = 40'hF0E1D2C3B4;
    exp_q.push_back({5'd13, w});
    send_word(w, 2);
    wait_done();
    check("t6_writes", 64'(wr_cnt - wr0), 64'd2);
    check("t6_bytes", 64'(hs_cnt - hs0), 64'd10);
    check("t6_one_done", 64'(done_cnt - done0), 64'd1);
    check("t6_addr_after", 64'(wr_addr), 64'd14);

    repeat (3) @(negedge clk);
    check_idle_outputs("end");
    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Write-side counterpart of the instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles INSTRUCTION_WIDTH-bit instruction words, MSB byte first.
- Writes each word into the instruction memory at consecutive addresses starting at a programmable base, wrapping modulo 2^PC_WIDTH.
- Holds the core in stall while loading, replacing file-based preload for in-system programming.

Parameters:
INSTRUCTION_WIDTH, 40, instruction word width; must match instruction memory.
PC_WIDTH, 5, memory address width.
NBYTES (localparam), ceil(INSTRUCTION_WIDTH/8) = 5, bytes per word.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; begins a load (honoured only in IDLE).
base_addr  input  PC_WIDTH  first write address, sampled on start.
length  input  PC_WIDTH+1  number of words to load (0..2^PC_WIDTH), sampled on start.
in_data  input  8  stream byte.
in_valid  input  1  in_data valid.
in_ready  output  1  loader accepts a byte this cycle.
wr_en  output  1  memory write strobe, one cycle per word.
wr_addr  output  PC_WIDTH  memory write address.
wr_data  output  INSTRUCTION_WIDTH  memory write data.
busy  output  1  load in progress; core must stall.
done  output  1  one-cycle pulse at end of a load.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. in_ready, wr_en, busy, done=0. wr_addr, wr_data, byte counter and word counter=0. Takes effect immediately, including mid-load. A partially assembled word is discarded and never written.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - in_ready=0, busy=0; bytes on the stream are not consumed.
  - On start with length!=0: latch base_addr into wr_addr, latch length into the word counter, clear byte counter, go to RECV.
  - On start with length==0: go straight to DONE; no write occurs.
- RECV:
  - in_ready=1, busy=1.
  - Byte handshake = in_valid & in_ready.
  - Each handshake shifts the shift register left by 8 and inserts in_data in the LSBs, so the first byte ends up most significant.
  - If INSTRUCTION_WIDTH is not a multiple of 8, the surplus MSBs of the first byte are dropped.
  - On the NBYTES-th handshake, go to WRITE.
  - in_valid low stalls indefinitely; there is no timeout.
- WRITE (exactly one cycle):
  - wr_en=1, wr_data=assembled word, wr_addr=current address; in_ready=0, busy=1.
  - Next cycle: wr_addr increments modulo 2^PC_WIDTH (base 31 wraps to 0), word counter decrements, byte counter clears.
  - Go to DONE if the counter was 1, else back to RECV.
- DONE (one cycle): done=1, busy=1, in_ready=0; go to IDLE.
- start outside IDLE is ignored; base_addr/length changes outside the start cycle have no effect.
- Latency:
  - Last byte handshake at cycle N → wr_en high at N+1.
  - Final word → done high at N+2, busy low at N+3.
  - Minimum per-word cost with continuous valid: NBYTES+1 cycles.
- wr_data holds its value when wr_en=0; wr_addr always shows the next write address.
- length=2^PC_WIDTH writes every location exactly once and ends with wr_addr back at base_addr.

Test Plan:
- Reset, then start base=0 length=1, bytes 12 34 56 78 9A back-to-back → single wr_en at addr 0 with data 40'h123456789A; done 2 cycles after the last byte; busy low afterwards.
- start base=3 length=3, 15 bytes with random in_valid gaps → writes at 3,4,5 with the correct words, in order; in_ready=0 in each WRITE cycle; no byte lost or duplicated.
- start base=30 length=4 → wr_addr sequence 30, 31, 0, 1.
- start length=0 → done the next cycle; no wr_en; in_ready never high.
- Drive rst_n low after 3 bytes of a word, then restart length=1 with 5 new bytes → no write from the aborted word; new word written correctly at the new base.
- Second start pulse mid-load and in_valid asserted while IDLE → both ignored; no bytes consumed in IDLE; original load completes unchanged.
